pcie_rx_cpl_extractor: RTL
==========================

# pcie_rx_cpl_extractor

Receive-side completion extractor between the PCIe endpoint core's 64-bit AXI4-Stream RX interface and the user PCIe stream generator. It parses incoming TLPs and keeps only successful Completions-with-Data (CplD). It strips the 3DW header, realigns the DW-misaligned payload into 64-bit words, and presents each word with its completion tag on the generator's `dma_tag` / `dma_data_valid` / `dma_data` inputs. All other TLPs are discarded and counted.

## Interface
- `CNT_W`, default 16: width of the saturating discard counter.
- `clk_i`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_tdata_i`  in  64  RX beat. DW0 is in [31:0], DW1 in [63:32].
- `rx_tkeep_i`  in  8  byte enables. Only 8'hFF and 8'h0F are legal.
- `rx_tlast_i`  in  1  last beat of TLP.
- `rx_tvalid_i`  in  1  beat valid.
- `rx_tready_o`  out  1  held 1 whenever `rst_n`=1. The block never back-pressures.
- `dma_tag_o`  out  8  tag of the completion the current word belongs to.
- `dma_data_valid_o`  out  1  one-cycle qualifier per output word. There is no ready signal.
- `dma_data_o`  out  64  payload word. The lower-addressed DW is in [31:0].
- `cpl_err_o`  out  1  one-cycle pulse when a CplD/Cpl with status ≠ 0 is dropped.
- `len_err_o`  out  1  one-cycle pulse when the received data-DW count ≠ header Length.
- `discard_cnt_o`  out  CNT_W  count of non-forwarded TLPs. Saturates at all-ones.

## Operation
- Header decode, beat 0 (DW0/DW1):
  - fmt = DW0[30:29], type = DW0[28:24], L = DW0[9:0]. L = 0 means 1024.
  - status = DW1[15:13].
- Header decode, beat 1: tag = DW2[15:8], taken from `rx_tdata_i[15:8]`. Payload DW0 is in `rx_tdata_i[63:32]`.
- Forward condition: fmt=2'b10, type=5'b01010, status=3'b000, and `rx_tlast_i`=0 on beat 0.
  - Otherwise the TLP is skipped until `tlast`.
  - `discard_cnt_o` increments on beat 0 of every skipped TLP.
  - `cpl_err_o` also pulses if type = 01010 and status ≠ 0.
- States:
  - IDLE: awaits beat 0. Forward → HDR; else SKIP. If beat 0 also has `tlast`, stay IDLE.
  - HDR: on beat 1, latch tag and `pending` ← [63:32]; dw_cnt ← 1. `tlast` → IDLE with flush.
  - DATA: each beat emits {`rx_tdata_i[31:0]`, `pending`}.
    - tkeep=FF: `pending` ← [63:32], dw_cnt += 2.
    - tkeep=0F: dw_cnt += 1, no new pending.
    - `tlast` → IDLE; flush if a pending DW remains, i.e. tkeep=FF.
  - SKIP: consume beats. `tlast` → IDLE.
- Flush: emits {32'h0, `pending`} as one extra word. This covers odd L.
- Output word count per CplD = ceil(L/2).
- Length check: on the `tlast` beat of a forwarded TLP, if final dw_cnt ≠ L (11-bit compare, 1024 legal), pulse `len_err_o`. Words are still forwarded.
- dw_cnt is 11 bits and wraps silently beyond 2047. This is covered by `len_err_o`.
- No tag filtering. Tags are passed unchanged; the downstream block routes by tag.

## Timing
- All outputs registered.
- Reset values:
  - `rx_tready_o`=0, `dma_data_valid_o`=0, `dma_data_o`=0, `dma_tag_o`=0.
  - `cpl_err_o`=0, `len_err_o`=0, `discard_cnt_o`=0, state=IDLE.
- Latency:
  - A data word appears one cycle after the accepted beat that completes it.
  - A flush word appears one cycle after the `tlast` beat.
- `dma_tag_o` is valid in every cycle `dma_data_valid_o`=1, including flush.
- `rx_tvalid_i`=0 mid-TLP: state and `pending` are held, and `dma_data_valid_o`=0 on the following cycle.
- Back-to-back TLPs with no idle cycle are supported.
  - A flush word overlaps the next TLP's beat 0, which produces no output, so there is no conflict.
  - The tag of the flush word is the old tag. The new tag is latched only on the next beat 1.
- `len_err_o` and `cpl_err_o` assert one cycle after the triggering beat.
- Reset mid-TLP: return to IDLE and drop `pending`; no output is produced. `rst_n` is shared with the core, so the RX stream restarts at a TLP boundary.

## Test plan
- **CplD, L=32, tag 8'h00, payload DWs 0..31 = 32'h0..32'h1F, continuous tvalid:**
  - 16 words: first {32'h1, 32'h0}, last {32'h1F, 32'h1E}.
  - Tag 0 on each word, no flush, no errors.
- **CplD, L=3, tag 8'h01:**
  - Words {D1,D0} then flush {0,D2} on the cycle after `tlast`.
  - A back-to-back second CplD (tag 8'h00) has its first word tagged 8'h00.
- **CplD, L=1 (tlast on beat 1):** exactly one word, {32'h0, D0}.
- **MWr (fmt=11, type=00000) 2 beats, then Cpl with status=3'b001:**
  - No `dma_data_valid_o`.
  - `discard_cnt_o`=2.
  - `cpl_err_o` pulses once.
- **CplD with header L=4 but 3 data DWs sent:** 2 words forwarded, and `len_err_o` pulses one cycle after `tlast`.
- **CplD, L=16, with random tvalid gaps, then `rst_n` low mid-second-TLP:**
  - All 8 words are correct.
  - After reset, all outputs are 0 and a new CplD decodes correctly.

Source files
------------

// File: rtl/pcie_rx_cpl_extractor.sv
// Completion extractor: keeps successful CplD TLPs from a 64-bit AXI4-Stream RX port,
// strips the 3DW header and realigns payload DWs into 64-bit words tagged with the completion tag.
module pcie_rx_cpl_extractor #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [63:0]      rx_tdata_i,
    input  logic [7:0]       rx_tkeep_i,
    input  logic             rx_tlast_i,
    input  logic             rx_tvalid_i,
    output logic             rx_tready_o,
    output logic [7:0]       dma_tag_o,
    output logic             dma_data_valid_o,
    output logic [63:0]      dma_data_o,
    output logic             cpl_err_o,
    output logic             len_err_o,
    output logic [CNT_W-1:0] discard_cnt_o
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, SKIP} state_t;

    state_t             state, state_d;
    logic [31:0]        pending, pending_d;
    logic [10:0]        dw_cnt, dw_cnt_d, cnt_next;
    logic [10:0]        len, len_d;
    logic               flush, flush_d;
    logic [7:0]         tag_d;
    logic [63:0]        data_d;
    logic               valid_d, cpl_err_d, len_err_d;
    logic [CNT_W-1:0]   discard_d;

    logic               beat;
    logic [1:0]         hdr_fmt;
    logic [4:0]         hdr_type;
    logic [9:0]         hdr_len;
    logic [2:0]         hdr_status;
    logic               is_cpl, fwd;

    assign beat       = rx_tvalid_i & rx_tready_o;
    assign hdr_fmt    = rx_tdata_i[30:29];
    assign hdr_type   = rx_tdata_i[28:24];
    assign hdr_len    = rx_tdata_i[9:0];
    assign hdr_status = rx_tdata_i[47:45];
    assign is_cpl     = (hdr_type == 5'b01010);
    assign fwd        = (hdr_fmt == 2'b10) && is_cpl && (hdr_status == 3'b000) && !rx_tlast_i;

    always_comb begin
        state_d   = state;
        pending_d = pending;
        dw_cnt_d  = dw_cnt;
        cnt_next  = dw_cnt;
        len_d     = len;
        flush_d   = 1'b0;
        tag_d     = dma_tag_o;
        data_d    = dma_data_o;
        valid_d   = 1'b0;
        cpl_err_d = 1'b0;
        len_err_d = 1'b0;
        discard_d = discard_cnt_o;

        // Deferred flush from a DATA tlast lands on the next TLP's beat 0, which never emits.
        if (flush) begin
            valid_d = 1'b1;
            data_d  = {32'h0, pending};
        end

        if (beat) begin
            unique case (state)
                IDLE: begin
                    len_d = {(hdr_len == 10'd0), hdr_len};
                    if (fwd) begin
                        state_d = HDR;
                    end else begin
                        if (discard_cnt_o != '1)
                            discard_d = discard_cnt_o + 1'b1;
                        cpl_err_d = is_cpl && (hdr_status != 3'b000);
                        state_d   = rx_tlast_i ? IDLE : SKIP;
                    end
                end
                HDR: begin
                    tag_d     = rx_tdata_i[15:8];
                    pending_d = rx_tdata_i[63:32];
                    dw_cnt_d  = 11'd1;
                    if (rx_tlast_i) begin
                        state_d   = IDLE;
                        valid_d   = 1'b1;
                        data_d    = {32'h0, rx_tdata_i[63:32]};
                        len_err_d = (len != 11'd1);
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    valid_d = 1'b1;
                    data_d  = {rx_tdata_i[31:0], pending};
                    if (rx_tkeep_i == 8'hFF) begin
                        pending_d = rx_tdata_i[63:32];
                        cnt_next  = dw_cnt + 11'd2;
                    end else begin
                        cnt_next  = dw_cnt + 11'd1;
                    end
                    dw_cnt_d = cnt_next;
                    if (rx_tlast_i) begin
                        state_d   = IDLE;
                        flush_d   = (rx_tkeep_i == 8'hFF);
                        len_err_d = (cnt_next != len);
                    end
                end
                SKIP: begin
                    if (rx_tlast_i)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state            <= IDLE;
            pending          <= '0;
            dw_cnt           <= '0;
            len              <= '0;
            flush            <= 1'b0;
            rx_tready_o      <= 1'b0;
            dma_tag_o        <= '0;
            dma_data_valid_o <= 1'b0;
            dma_data_o       <= '0;
            cpl_err_o        <= 1'b0;
            len_err_o        <= 1'b0;
            discard_cnt_o    <= '0;
        end else begin
            state            <= state_d;
            pending          <= pending_d;
            dw_cnt           <= dw_cnt_d;
            len              <= len_d;
            flush            <= flush_d;
            rx_tready_o      <= 1'b1;
            dma_tag_o        <= tag_d;
            dma_data_valid_o <= valid_d;
            dma_data_o       <= data_d;
            cpl_err_o        <= cpl_err_d;
            len_err_o        <= len_err_d;
            discard_cnt_o    <= discard_d;
        end
    end

endmodule
